// File: rtl/fetch_queue_pkg.sv
// Shared widths and entry layout for the fetch queue.
// Imported by fetch_queue and fetch_queue_issue_sel.
package fetch_queue_pkg;

  localparam int ADDR_W   = 64;
  localparam int INS_W    = 32;
  localparam int NDEC     = 4;
  localparam int BUNDLE_W = NDEC * INS_W;
  localparam int PID_W    = 32;
  localparam int TID_W    = 64;
  localparam int MAJ_W    = 64;
  localparam int IDX_W    = 7;
  localparam int QLEN     = 2 ** IDX_W;
  localparam int CNT_W    = IDX_W + 1;

  // One bundle's worth of slots is always kept free.
  localparam int FULL_AT  = QLEN - NDEC;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [INS_W-1:0]  ins;
    logic [ADDR_W-1:0] addr;
    logic [PID_W-1:0]  pid;
    logic [TID_W-1:0]  tid;
    logic [MAJ_W-1:0]  maj;
  } entry_t;

endpackage

// File: rtl/fetch_queue_issue_sel.sv
// Pairs available decoders (1..4 in order) with the oldest queued slots.
// Ports: avail[4], count in; offset[4], en[4], issued out (combinational).
module fetch_queue_issue_sel
  import fetch_queue_pkg::*;
(
  input  logic [NDEC-1:0]      avail,
  input  cnt_t                 count,
  output logic [NDEC-1:0][1:0] offset,
  output logic [NDEC-1:0]      en,
  output logic [2:0]           issued
);

  logic [2:0] n;

  always_comb begin
    n      = '0;
    offset = '0;
    en     = '0;
    for (int d = 0; d < NDEC; d++) begin
      if (avail[d] && (cnt_t'(n) < count)) begin
        en[d]     = 1'b1;
        offset[d] = n[1:0];
        n         = n + 3'd1;
      end
    end
    issued = n;
  end

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and four decoders.
// In: clock_i, reset_i (async high), bundle write/sideband, decodeNAvailable_i.
// Out: decoderNEn_o/decoderNIns_o (registered), front_o, back_o, isFull_o, isEmpty_o.
// FETCH_QUEUE_DEBUG_EN: enables a simulation-only $display trace.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int fetch_queue_instance = 0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              bundleWrite_i,
  input  logic [ADDR_W-1:0] bundleAddress_i,
  input  logic [1:0]        bundleLen_i,
  input  logic [PID_W-1:0]  bundlePid_i,
  input  logic [TID_W-1:0]  bundleTid_i,
  input  logic [MAJ_W-1:0]  bundleStartMajId_i,
  input  logic [BUNDLE_W-1:0] bundle_i,
  input  logic              decode1Available_i,
  input  logic              decode2Available_i,
  input  logic              decode3Available_i,
  input  logic              decode4Available_i,
  output logic              decoder1En_o,
  output logic              decoder2En_o,
  output logic              decoder3En_o,
  output logic              decoder4En_o,
  output logic [INS_W-1:0]  decoder1Ins_o,
  output logic [INS_W-1:0]  decoder2Ins_o,
  output logic [INS_W-1:0]  decoder3Ins_o,
  output logic [INS_W-1:0]  decoder4Ins_o,
  output logic [IDX_W-1:0]  front_o,
  output logic [IDX_W-1:0]  back_o,
  output logic              isFull_o,
  output logic              isEmpty_o
);

  entry_t mem [QLEN];

  idx_t front, back;
  cnt_t count;

  logic [NDEC-1:0]            en_q;
  logic [NDEC-1:0][INS_W-1:0] ins_q;

  logic [NDEC-1:0]      avail;
  logic [NDEC-1:0][1:0] offset;
  logic [NDEC-1:0]      sel_en;
  logic [2:0]           issued;
  logic                 full, wr;
  logic [2:0]           wr_len;

  assign avail = {decode4Available_i, decode3Available_i,
                  decode2Available_i, decode1Available_i};

  assign full   = count >= cnt_t'(FULL_AT);
  assign wr     = bundleWrite_i && !full;
  assign wr_len = wr ? {1'b0, bundleLen_i} + 3'd1 : 3'd0;

  fetch_queue_issue_sel u_sel (
    .avail  (avail),
    .count  (count),
    .offset (offset),
    .en     (sel_en),
    .issued (issued)
  );

  // Entry RAM: contents are only meaningful below count, so no reset.
  always_ff @(posedge clock_i) begin
    if (wr) begin
      for (int i = 0; i < NDEC; i++) begin
        if (2'(i) <= bundleLen_i) begin
          mem[back + idx_t'(i)] <= '{
            ins:  bundle_i[BUNDLE_W-1-INS_W*i -: INS_W],
            addr: bundleAddress_i + ADDR_W'(4 * i),
            pid:  bundlePid_i,
            tid:  bundleTid_i,
            maj:  bundleStartMajId_i + MAJ_W'(i)
          };
        end
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      front <= '0;
      back  <= '0;
      count <= '0;
      en_q  <= '0;
      ins_q <= '0;
    end else begin
      front <= front + idx_t'(issued);
      back  <= back + idx_t'(wr_len);
      count <= count + cnt_t'(wr_len) - cnt_t'(issued);
      en_q  <= sel_en;
      for (int d = 0; d < NDEC; d++) begin
        if (sel_en[d]) begin
          ins_q[d] <= mem[front + idx_t'(offset[d])].ins;
        end
      end
    end
  end

`ifdef FETCH_QUEUE_DEBUG_EN
  always @(posedge clock_i) begin
    if (!reset_i) begin
      if (wr) begin
        $display("fq%0d enq back=%0d addr=%h pid=%h tid=%h maj=%h ins=%h",
                 fetch_queue_instance, back, bundleAddress_i, bundlePid_i,
                 bundleTid_i, bundleStartMajId_i, bundle_i);
      end
      for (int d = 0; d < NDEC; d++) begin
        if (sel_en[d]) begin
          $display("fq%0d dec%0d front=%0d ins=%h", fetch_queue_instance,
                   d + 1, front + idx_t'(offset[d]),
                   mem[front + idx_t'(offset[d])].ins);
        end
      end
    end
  end
`endif

  // Sideband fields are kept for the trace and future consumers.
  logic unused_sideband;
  assign unused_sideband = ^{mem[front].addr, mem[front].pid,
                             mem[front].tid, mem[front].maj,
                             32'(fetch_queue_instance)};

  assign decoder1En_o  = en_q[0];
  assign decoder2En_o  = en_q[1];
  assign decoder3En_o  = en_q[2];
  assign decoder4En_o  = en_q[3];
  assign decoder1Ins_o = ins_q[0];
  assign decoder2Ins_o = ins_q[1];
  assign decoder3Ins_o = ins_q[2];
  assign decoder4Ins_o = ins_q[3];
  assign front_o       = front;
  assign back_o        = back;
  assign isFull_o      = full;
  assign isEmpty_o     = count == '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: queued instructions are popped
// in order as decoders are modelled to accept them.
module tb_fetch_queue;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_in = 1'b0;
  logic [63:0]  addr_in = '0;
  logic [1:0]   len_in = '0;
  logic [31:0]  pid_in = '0;
  logic [63:0]  tid_in = '0;
  logic [63:0]  maj_in = '0;
  logic [127:0] bundle_in = '0;
  logic [3:0]   av = '0;
  logic         en1, en2, en3, en4;
  logic [31:0]  ins1, ins2, ins3, ins4;
  logic [6:0]   front, back;
  logic         full, empty;

  fetch_queue dut (
    .clock_i            (clk),
    .reset_i            (rst),
    .bundleWrite_i      (wr_in),
    .bundleAddress_i    (addr_in),
    .bundleLen_i        (len_in),
    .bundlePid_i        (pid_in),
    .bundleTid_i        (tid_in),
    .bundleStartMajId_i (maj_in),
    .bundle_i           (bundle_in),
    .decode1Available_i (av[0]),
    .decode2Available_i (av[1]),
    .decode3Available_i (av[2]),
    .decode4Available_i (av[3]),
    .decoder1En_o       (en1),
    .decoder2En_o       (en2),
    .decoder3En_o       (en3),
    .decoder4En_o       (en4),
    .decoder1Ins_o      (ins1),
    .decoder2Ins_o      (ins2),
    .decoder3Ins_o      (ins3),
    .decoder4Ins_o      (ins4),
    .front_o            (front),
    .back_o             (back),
    .isFull_o           (full),
    .isEmpty_o          (empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sb [$];
  logic [31:0] last_ins [4];
  logic [6:0]  ef = '0;
  logic [6:0]  eb = '0;
  logic [31:0] seq = 32'h1000_0000;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mkb();
    logic [127:0] b;
    b = {seq, seq + 32'd1, seq + 32'd2, seq + 32'd3};
    seq = seq + 32'd4;
    return b;
  endfunction

  task automatic check_all(input string tag, input logic [3:0] exp_en);
    check({tag, "_en"}, {60'd0, en4, en3, en2, en1}, {60'd0, exp_en});
    check({tag, "_ins1"}, {32'd0, ins1}, {32'd0, last_ins[0]});
    check({tag, "_ins2"}, {32'd0, ins2}, {32'd0, last_ins[1]});
    check({tag, "_ins3"}, {32'd0, ins3}, {32'd0, last_ins[2]});
    check({tag, "_ins4"}, {32'd0, ins4}, {32'd0, last_ins[3]});
    check({tag, "_front"}, {57'd0, front}, {57'd0, ef});
    check({tag, "_back"}, {57'd0, back}, {57'd0, eb});
    check({tag, "_full"}, {63'd0, full}, {63'd0, sb.size() >= 124});
    check({tag, "_empty"}, {63'd0, empty}, {63'd0, sb.size() == 0});
  endtask

  task automatic step(input string tag, input bit w, input logic [1:0] len,
                      input logic [127:0] b, input logic [3:0] a);
    int pre;
    int n;
    logic [3:0] exp_en;
    wr_in     = w;
    len_in    = len;
    bundle_in = b;
    av        = a;
    addr_in   = 64'h8000 + 64'(seq);
    maj_in    = maj_in + 64'd4;
    pre       = sb.size();
    n         = 0;
    exp_en    = '0;
    for (int d = 0; d < 4; d++) begin
      if (a[d] && n < pre) begin
        exp_en[d]   = 1'b1;
        last_ins[d] = sb.pop_front();
        n++;
      end
    end
    if (w && pre < 124) begin
      for (int i = 0; i <= int'(len); i++) begin
        sb.push_back(b[127-32*i -: 32]);
      end
      eb = eb + 7'(int'(len) + 1);
    end
    ef = ef + 7'(n);
    @(posedge clk);
    #1;
    check_all(tag, exp_en);
  endtask

  initial begin
    for (int d = 0; d < 4; d++) last_ins[d] = '0;

    #12;
    check_all("reset", 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    step("wr_abcd", 1'b1, 2'd3,
         {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD}, 4'b0000);
    step("iss_all", 1'b0, 2'd0, '0, 4'b1111);
    check("ins1_a", {32'd0, ins1}, 64'hAAAAAAAA);
    check("ins4_d", {32'd0, ins4}, 64'hDDDDDDDD);
    step("idle", 1'b0, 2'd0, '0, 4'b0000);

    step("wr_b1", 1'b1, 2'd3, mkb(), 4'b0000);
    step("wr_b2", 1'b1, 2'd3, mkb(), 4'b0000);
    step("av_4", 1'b0, 2'd0, '0, 4'b1000);
    step("av_24", 1'b0, 2'd0, '0, 4'b1010);
    step("av_124a", 1'b0, 2'd0, '0, 4'b1011);
    step("av_124b", 1'b0, 2'd0, '0, 4'b1011);
    check("front_12", {57'd0, front}, 64'd12);

    for (int k = 0; k < 32; k++) step("fill", 1'b1, 2'd3, mkb(), 4'b0000);
    check("full_at_124", {63'd0, full}, 64'd1);
    step("drop_len0", 1'b1, 2'd0, mkb(), 4'b0000);

    for (int k = 0; k < 32; k++) step("drain", 1'b0, 2'd0, '0, 4'b1111);

    for (int k = 0; k < 120; k++) begin
      step("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           mkb(), 4'($urandom_range(0, 15)));
    end
    step("both", 1'b1, 2'd2, mkb(), 4'b0111);

    step("pre_rst", 1'b1, 2'd3, mkb(), 4'b0001);
    @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    ef = '0;
    eb = '0;
    for (int d = 0; d < 4; d++) last_ins[d] = '0;
    check_all("async_rst", 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_wr", 1'b1, 2'd1, mkb(), 4'b0000);
    step("post_iss", 1'b0, 2'd0, '0, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
